// File: rtl/machine_interrupt_source_pkg.sv
// Shared CSR-side types and constants for the machine interrupt source:
// MMIO word indices, mtimecmp reset value and the external interrupt code type.
package machine_interrupt_source_pkg;

  localparam int CSR_CAUSE_CODE_WIDTH = 5;

  typedef logic [CSR_CAUSE_CODE_WIDTH-1:0] ExternalIrqCodePath;

  localparam logic [2:0] MTIME_LO    = 3'd0;
  localparam logic [2:0] MTIME_HI    = 3'd1;
  localparam logic [2:0] MTIMECMP_LO = 3'd2;
  localparam logic [2:0] MTIMECMP_HI = 3'd3;
  localparam logic [2:0] EXT_STATUS  = 3'd4;

  localparam logic [63:0] MTIMECMP_RESET_VALUE = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/machine_interrupt_source_if.sv
// 32-bit MMIO request/response port of the machine interrupt source.
interface machine_interrupt_source_if;

  logic        reqValid;
  logic        reqWE;
  logic [2:0]  reqAddr;
  logic [31:0] reqWData;
  logic        rspValid;
  logic [31:0] rspRData;

  modport master (
    output reqValid, reqWE, reqAddr, reqWData,
    input  rspValid, rspRData
  );

  modport slave (
    input  reqValid, reqWE, reqAddr, reqWData,
    output rspValid, rspRData
  );

endinterface

// File: rtl/machine_interrupt_source_edge.sv
// Synchronizes an asynchronous interrupt request and its code through SYNC_STAGES
// flops and emits a one-cycle rise pulse with the code aligned to that pulse.
module irq_edge_synchronizer #(
  parameter int SYNC_STAGES = 2,
  parameter int CODE_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [CODE_WIDTH-1:0] code,
  output logic                  rise,
  output logic [CODE_WIDTH-1:0] rise_code
);

  logic                  req_sync;
  logic [CODE_WIDTH-1:0] code_sync;
  logic                  req_prev;

  if (SYNC_STAGES == 0) begin : g_bypass
    assign req_sync  = req;
    assign code_sync = code;
  end else begin : g_chain
    logic [SYNC_STAGES-1:0]                 req_chain;
    logic [SYNC_STAGES-1:0][CODE_WIDTH-1:0] code_chain;

    // The code travels through an identical chain so it lines up with the request edge.
    always_ff @(posedge clk) begin
      if (rst) begin
        req_chain  <= '0;
        code_chain <= '0;
      end else begin
        req_chain[0]  <= req;
        code_chain[0] <= code;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          req_chain[i]  <= req_chain[i-1];
          code_chain[i] <= code_chain[i-1];
        end
      end
    end

    assign req_sync  = req_chain[SYNC_STAGES-1];
    assign code_sync = code_chain[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) req_prev <= 1'b0;
    else     req_prev <= req_sync;
  end

  assign rise      = req_sync & ~req_prev;
  assign rise_code = code_sync;

endmodule

// File: rtl/machine_interrupt_source.sv
// Machine timer (mtime/mtimecmp -> mtip) and latched external interrupt (meip/meipCode)
// behind a 32-bit MMIO port with a fixed one-cycle read latency.
module machine_interrupt_source
  import machine_interrupt_source_pkg::*;
#(
  parameter int PRESCALE       = 1,
  parameter int EXT_CODE_WIDTH = $bits(ExternalIrqCodePath),
  parameter int SYNC_STAGES    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  machine_interrupt_source_if.slave bus,
  input  logic                      extIrqReq,
  input  logic [EXT_CODE_WIDTH-1:0] extIrqCode,
  output logic                      mtip,
  output logic                      meip,
  output logic [EXT_CODE_WIDTH-1:0] meipCode
);

  localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);

  logic [15:0]               prescale_cnt;
  logic [63:0]               mtime, mtime_next;
  logic [63:0]               mtimecmp, mtimecmp_next;
  logic [31:0]               rdata;
  logic                      tick, wr, rd, ext_clear, ext_rise;
  logic [EXT_CODE_WIDTH-1:0] ext_rise_code;

  assign wr        = bus.reqValid & bus.reqWE;
  assign rd        = bus.reqValid & ~bus.reqWE;
  assign tick      = (prescale_cnt == PRESCALE_LAST);
  assign ext_clear = wr && (bus.reqAddr == EXT_STATUS) && bus.reqWData[0];

  irq_edge_synchronizer #(
    .SYNC_STAGES (SYNC_STAGES),
    .CODE_WIDTH  (EXT_CODE_WIDTH)
  ) u_edge (
    .clk       (clk),
    .rst       (rst),
    .req       (extIrqReq),
    .code      (extIrqCode),
    .rise      (ext_rise),
    .rise_code (ext_rise_code)
  );

  // NOTE: every always_comb assigns its outputs a default first, so no latch can form.
  always_comb begin
    mtime_next = mtime;
    if (wr && bus.reqAddr == MTIME_LO)      mtime_next[31:0]  = bus.reqWData;
    else if (wr && bus.reqAddr == MTIME_HI) mtime_next[63:32] = bus.reqWData;
    else if (tick)                          mtime_next        = mtime + 64'd1;
  end

  always_comb begin
    mtimecmp_next = mtimecmp;
    if (wr && bus.reqAddr == MTIMECMP_LO)      mtimecmp_next[31:0]  = bus.reqWData;
    else if (wr && bus.reqAddr == MTIMECMP_HI) mtimecmp_next[63:32] = bus.reqWData;
  end

  // Read mux looks at current-state registers, so a same-cycle update is never visible.
  always_comb begin
    rdata = '0;
    case (bus.reqAddr)
      MTIME_LO:    rdata = mtime[31:0];
      MTIME_HI:    rdata = mtime[63:32];
      MTIMECMP_LO: rdata = mtimecmp[31:0];
      MTIMECMP_HI: rdata = mtimecmp[63:32];
      EXT_STATUS:  rdata = 32'({meipCode, meip});
      default:     rdata = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; next values come from always_comb.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescale_cnt <= '0;
      mtime        <= '0;
      mtimecmp     <= MTIMECMP_RESET_VALUE;
      mtip         <= 1'b0;
      bus.rspValid <= 1'b0;
      bus.rspRData <= '0;
    end else begin
      prescale_cnt <= tick ? 16'd0 : prescale_cnt + 16'd1;
      mtime        <= mtime_next;
      mtimecmp     <= mtimecmp_next;
      mtip         <= (mtime_next >= mtimecmp_next);
      bus.rspValid <= rd;
      if (rd) bus.rspRData <= rdata;
    end
  end

  // First request wins; a rise coinciding with a clear re-arms with the new code.
  always_ff @(posedge clk) begin
    if (rst) begin
      meip     <= 1'b0;
      meipCode <= '0;
    end else if (ext_rise && (!meip || ext_clear)) begin
      meip     <= 1'b1;
      meipCode <= ext_rise_code;
    end else if (ext_clear) begin
      meip     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_machine_interrupt_source.sv
// Directed plus randomized bench for machine_interrupt_source, using a cycle-count
// timer model and explicit pending-state expectations.
module tb_machine_interrupt_source;
  import machine_interrupt_source_pkg::*;

  localparam int CW   = 5;
  localparam int SYNC = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ext_req = 1'b0;
  logic [CW-1:0] ext_code = '0;
  logic          mtip1, meip1, mtip4, meip4;
  logic [CW-1:0] code1, code4;

  machine_interrupt_source_if bus1 ();
  machine_interrupt_source_if bus4 ();

  machine_interrupt_source #(.PRESCALE(1), .EXT_CODE_WIDTH(CW), .SYNC_STAGES(SYNC)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .extIrqReq(ext_req), .extIrqCode(ext_code),
    .mtip(mtip1), .meip(meip1), .meipCode(code1)
  );

  machine_interrupt_source #(.PRESCALE(4), .EXT_CODE_WIDTH(CW), .SYNC_STAGES(SYNC)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4), .extIrqReq(ext_req), .extIrqCode(ext_code),
    .mtip(mtip4), .meip(meip4), .meipCode(code4)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad   = 0;

  // Reference state: mtime is base + elapsed cycles since it was last loaded.
  logic [63:0] m_mt_base;
  int          m_mt_cyc;
  logic [63:0] m_cmp;
  logic        m_meip;
  logic [CW-1:0] m_code;
  int          rel;

  function automatic logic [63:0] model_mtime();
    return m_mt_base + 64'(cyc - m_mt_cyc);
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    logic [63:0] t;
    t = model_mtime();
    case (a)
      3'd0:    return t[31:0];
      3'd1:    return t[63:32];
      3'd2:    return m_cmp[31:0];
      3'd3:    return m_cmp[63:32];
      3'd4:    return 32'({m_code, m_meip});
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rel       = cyc;
    m_mt_base = 64'd0;
    m_mt_cyc  = cyc;
    m_cmp     = 64'hFFFF_FFFF_FFFF_FFFF;
    m_meip    = 1'b0;
    m_code    = '0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ext(input string tag);
    chk({tag, "/meip"}, 64'(meip1), 64'(m_meip));
    chk({tag, "/code"}, 64'(code1), 64'(m_code));
  endtask

  task automatic rd1(input logic [2:0] a, input string tag);
    logic [31:0] exp;
    chk({tag, "/mtip"}, 64'(mtip1), 64'(model_mtime() >= m_cmp));
    exp           = model_read(a);
    bus1.reqValid = 1'b1;
    bus1.reqWE    = 1'b0;
    bus1.reqAddr  = a;
    bus1.reqWData = $urandom;
    idle();
    bus1.reqValid = 1'b0;
    chk({tag, "/rspValid"}, 64'(bus1.rspValid), 64'(1'b1));
    chk({tag, "/rdata"}, 64'(bus1.rspRData), 64'(exp));
  endtask

  task automatic wr1(input logic [2:0] a, input logic [31:0] d, input string tag);
    logic [63:0] cur;
    cur           = model_mtime();
    bus1.reqValid = 1'b1;
    bus1.reqWE    = 1'b1;
    bus1.reqAddr  = a;
    bus1.reqWData = d;
    idle();
    bus1.reqValid = 1'b0;
    case (a)
      3'd0: begin m_mt_base = {cur[63:32], d}; m_mt_cyc = cyc; end
      3'd1: begin m_mt_base = {d, cur[31:0]};  m_mt_cyc = cyc; end
      3'd2: m_cmp[31:0]  = d;
      3'd3: m_cmp[63:32] = d;
      3'd4: if (d[0]) m_meip = 1'b0;
      default: ;
    endcase
    chk({tag, "/mtip"}, 64'(mtip1), 64'(model_mtime() >= m_cmp));
    chk({tag, "/rspValid"}, 64'(bus1.rspValid), 64'(1'b0));
  endtask

  task automatic rd4(input logic [2:0] a, input logic [31:0] exp, input string tag);
    chk({tag, "/mtip"}, 64'(mtip4), 64'(1'b0));
    bus4.reqValid = 1'b1;
    bus4.reqWE    = 1'b0;
    bus4.reqAddr  = a;
    bus4.reqWData = '0;
    idle();
    bus4.reqValid = 1'b0;
    chk({tag, "/rspValid"}, 64'(bus4.rspValid), 64'(1'b1));
    chk({tag, "/rdata"}, 64'(bus4.rspRData), 64'(exp));
  endtask

  initial begin
    logic [2:0]  a;
    logic [31:0] d;

    bus1.reqValid = 1'b0; bus1.reqWE = 1'b0; bus1.reqAddr = '0; bus1.reqWData = '0;
    bus4.reqValid = 1'b0; bus4.reqWE = 1'b0; bus4.reqAddr = '0; bus4.reqWData = '0;

    // Reset and reset values
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    chk("rst/mtip", 64'(mtip1), 64'(1'b0));
    chk("rst/meip", 64'(meip1), 64'(1'b0));
    chk("rst/code", 64'(code1), 64'(0));
    chk("rst/rspValid", 64'(bus1.rspValid), 64'(1'b0));
    chk("rst/rspRData", 64'(bus1.rspRData), 64'(0));

    // Back-to-back random reads for 40 cycles, then PRESCALE=4 timer must read 10
    for (int i = 0; i < 40; i++) rd1(3'($urandom_range(0, 7)), "boot_rd");
    rd4(3'd0, 32'((cyc - rel) / 4), "p4_mtime_lo");
    chk("p4_mtime_is_10", 64'(bus4.rspRData), 64'(10));
    rd4(3'd3, 32'hFFFF_FFFF, "p4_cmp_hi");
    idle();
    chk("idle/rspValid1", 64'(bus1.rspValid), 64'(1'b0));
    chk("idle/rspValid4", 64'(bus4.rspValid), 64'(1'b0));

    // Compare threshold at 20, then software raises mtimecmp
    wr1(3'd2, 32'd20, "thr_cmp_lo");
    wr1(3'd3, 32'd0, "thr_cmp_hi");
    wr1(3'd0, 32'd0, "thr_mtime_lo");
    for (int i = 0; i < 25; i++) rd1(3'd0, "thr_rd");
    wr1(3'd2, 32'd1000, "raise_cmp");

    // 64-bit wrap
    wr1(3'd0, 32'hFFFF_FFFF, "wrap_lo");
    wr1(3'd1, 32'hFFFF_FFFF, "wrap_hi");
    idle();
    rd1(3'd1, "wrap_rd_hi");
    chk("wrap_hi_zero", 64'(bus1.rspRData), 64'(0));
    rd1(3'd0, "wrap_rd_lo");

    // Write in a tick cycle suppresses the increment
    wr1(3'd0, 32'd5, "supp_wr");
    rd1(3'd0, "supp_rd");
    chk("supp_is_5", 64'(bus1.rspRData), 64'(5));
    rd1(3'd0, "supp_rd_next");

    // First external request wins
    ext_code = 5'd11;
    ext_req  = 1'b1;
    repeat (SYNC) idle();
    chk_ext("ext_before");
    idle();
    m_meip = 1'b1;
    m_code = 5'd11;
    chk_ext("ext_set");
    idle();
    ext_req = 1'b0;
    repeat (3) idle();
    ext_code = 5'd3;
    ext_req  = 1'b1;
    repeat (4) idle();
    ext_req = 1'b0;
    repeat (4) idle();
    chk_ext("ext_held");
    rd1(3'd4, "ext_status");
    chk("ext_status_17", 64'(bus1.rspRData), 64'(32'h17));

    // Level held high does not re-trigger after a clear
    ext_code = 5'd9;
    ext_req  = 1'b1;
    repeat (SYNC + 2) idle();
    chk_ext("hold_ignored");
    wr1(3'd4, 32'd1, "hold_clear");
    chk_ext("hold_cleared");
    repeat (6) idle();
    chk_ext("hold_stays_0");
    rd1(3'd4, "hold_status");
    ext_req = 1'b0;
    repeat (SYNC + 2) idle();
    ext_req = 1'b1;
    repeat (SYNC + 1) idle();
    m_meip = 1'b1;
    m_code = 5'd9;
    chk_ext("rearm");
    ext_req = 1'b0;
    repeat (SYNC + 2) idle();

    // Clear coinciding with a new rising edge: set wins with the new code
    ext_code = 5'd7;
    ext_req  = 1'b1;
    repeat (SYNC) idle();
    wr1(3'd4, 32'd1, "coincide_clear");
    m_meip = 1'b1;
    m_code = 5'd7;
    chk_ext("coincide");
    wr1(3'd4, 32'hFFFF_FFFE, "clear_bit0_only");
    chk_ext("no_clear_bit0_0");
    ext_req = 1'b0;
    repeat (SYNC + 2) idle();

    // Randomized register traffic against the model
    for (int i = 0; i < 80; i++) begin
      a = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) begin
        d = (a == 3'd1 || a == 3'd3) ? 32'($urandom_range(0, 1)) : $urandom;
        wr1(a, d, "rnd_wr");
      end else begin
        rd1(a, "rnd_rd");
      end
    end
    chk_ext("rnd_ext");

    // Reset mid-operation drops an in-flight read
    bus1.reqValid = 1'b1;
    bus1.reqWE    = 1'b0;
    bus1.reqAddr  = 3'd0;
    rst           = 1'b1;
    idle();
    bus1.reqValid = 1'b0;
    rst           = 1'b0;
    model_reset();
    chk("midrst/rspValid", 64'(bus1.rspValid), 64'(1'b0));
    chk("midrst/rspRData", 64'(bus1.rspRData), 64'(0));
    chk_ext("midrst");
    rd1(3'd2, "midrst_cmp_lo");
    rd1(3'd0, "midrst_mtime_lo");
    rd4(3'd0, 32'((cyc - rel) / 4), "midrst_p4");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
